// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection, per-stage stall/bubble steering, a status FSM
// that freezes the pipe after a non-AOK status retires, and saturating performance counters.
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_icode,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             halted,
   output logic [3:0]       prog_stat,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bub_cnt
);

   localparam logic [3:0] IC_MRMOVQ = 4'h5;
   localparam logic [3:0] IC_OPQ    = 4'h6;
   localparam logic [3:0] IC_JXX    = 4'h7;
   localparam logic [3:0] IC_RET    = 4'h9;
   localparam logic [3:0] IC_POPQ   = 4'hB;
   localparam logic [3:0] IC_NOP    = 4'h1;
   localparam logic [3:0] REG_NONE  = 4'hF;
   localparam logic [3:0] STAT_AOK  = 4'h1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_halted;
   logic [3:0]       r_prog_stat;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] r_ret_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bub_cnt;

   logic w_lu;
   logic w_rt;
   logic w_mp;
   logic w_m_exc;
   logic w_w_exc;
   logic w_retire;

   assign w_lu     = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) &&
                     (E_dstM != REG_NONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign w_rt     = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
   assign w_mp     = (E_icode == IC_JXX) && !e_Cnd;
   assign w_m_exc  = (m_stat != STAT_AOK);
   assign w_w_exc  = (W_stat != STAT_AOK);
   assign w_retire = (W_icode != IC_NOP) && (W_stat == STAT_AOK);

   // Reset flushes the pipe to nops; HALT freezes it; otherwise the hazard equations apply.
   // Load/use outranks ret, so D is held rather than bubbled when both are present.
   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
      if (rst) begin
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
      end else if (r_state == S_HALT) begin
         F_stall  = 1'b1;
         D_stall  = 1'b1;
         E_bubble = 1'b1;
         M_bubble = 1'b1;
         W_stall  = 1'b1;
      end else begin
         F_stall  = w_lu | w_rt;
         D_stall  = w_lu;
         D_bubble = w_mp | (w_rt & ~w_lu);
         E_bubble = w_mp | w_lu;
         M_bubble = w_m_exc | w_w_exc;
         W_stall  = w_w_exc;
         set_cc   = (E_icode == IC_OPQ) & ~w_m_exc & ~w_w_exc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_halted    <= 1'b0;
         r_prog_stat <= STAT_AOK;
         r_cyc_cnt   <= '0;
         r_ret_cnt   <= '0;
         r_stall_cnt <= '0;
         r_bub_cnt   <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (r_cyc_cnt != '1)
                  r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
               if (w_retire && (r_ret_cnt != '1))
                  r_ret_cnt <= r_ret_cnt + CNT_ONE;
               if (w_lu && (r_stall_cnt != '1))
                  r_stall_cnt <= r_stall_cnt + CNT_ONE;
               if (w_mp && (r_bub_cnt != '1))
                  r_bub_cnt <= r_bub_cnt + CNT_ONE;
               if (w_w_exc) begin
                  r_state     <= S_HALT;
                  r_halted    <= 1'b1;
                  r_prog_stat <= W_stat;
               end
            end
            S_HALT: begin
               r_state  <= S_HALT;
               r_halted <= 1'b1;
            end
            default: begin
               r_state  <= S_RUN;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign halted    = r_halted;
   assign prog_stat = r_prog_stat;
   assign cyc_cnt   = r_cyc_cnt;
   assign ret_cnt   = r_ret_cnt;
   assign stall_cnt = r_stall_cnt;
   assign bub_cnt   = r_bub_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic against a behavioural model,
// run on a full-width instance and a 4-bit-counter instance sharing the same inputs.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
   logic e_Cnd;

   logic        a_F_stall, a_D_stall, a_D_bubble, a_E_bubble, a_M_bubble, a_W_stall, a_set_cc, a_halted;
   logic [3:0]  a_prog_stat;
   logic [31:0] a_cyc, a_ret, a_stall, a_bub;
   logic        b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_M_bubble, b_W_stall, b_set_cc, b_halted;
   logic [3:0]  b_prog_stat;
   logic [3:0]  b_cyc, b_ret, b_stall, b_bub;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
      .W_icode(W_icode), .W_stat(W_stat),
      .F_stall(a_F_stall), .D_stall(a_D_stall), .D_bubble(a_D_bubble), .E_bubble(a_E_bubble),
      .M_bubble(a_M_bubble), .W_stall(a_W_stall), .set_cc(a_set_cc), .halted(a_halted),
      .prog_stat(a_prog_stat), .cyc_cnt(a_cyc), .ret_cnt(a_ret), .stall_cnt(a_stall), .bub_cnt(a_bub)
   );

   pipe_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
      .W_icode(W_icode), .W_stat(W_stat),
      .F_stall(b_F_stall), .D_stall(b_D_stall), .D_bubble(b_D_bubble), .E_bubble(b_E_bubble),
      .M_bubble(b_M_bubble), .W_stall(b_W_stall), .set_cc(b_set_cc), .halted(b_halted),
      .prog_stat(b_prog_stat), .cyc_cnt(b_cyc), .ret_cnt(b_ret), .stall_cnt(b_stall), .bub_cnt(b_bub)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a halted flag, the latched status, and unbounded counts clipped per width.
   bit     m_halted = 1'b0;
   int     m_pstat  = 1;
   longint m_cnt[2][4];
   longint m_max[2] = '{64'hFFFF_FFFF, 64'd15};

   initial begin
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 4; j++)
            m_cnt[i][j] = 0;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit lu, rt, mp, mx, wx;
         bit e_fs, e_ds, e_db, e_eb, e_mb, e_ws, e_cc;
         bit inc[4];
         lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
         rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
         mp = (E_icode == 4'h7) && !e_Cnd;
         mx = (m_stat != 4'h1);
         wx = (W_stat != 4'h1);
         if (rst) begin
            {e_fs, e_ds, e_db, e_eb, e_mb, e_ws, e_cc} = 7'b0011100;
         end else if (m_halted) begin
            {e_fs, e_ds, e_db, e_eb, e_mb, e_ws, e_cc} = 7'b1101110;
         end else begin
            e_fs = lu || rt;
            e_ds = lu;
            e_db = mp || (rt && !lu);
            e_eb = mp || lu;
            e_mb = mx || wx;
            e_ws = wx;
            e_cc = (E_icode == 4'h6) && !mx && !wx;
         end
         chk("F_stall",  {63'd0, a_F_stall},  {63'd0, e_fs});
         chk("D_stall",  {63'd0, a_D_stall},  {63'd0, e_ds});
         chk("D_bubble", {63'd0, a_D_bubble}, {63'd0, e_db});
         chk("E_bubble", {63'd0, a_E_bubble}, {63'd0, e_eb});
         chk("M_bubble", {63'd0, a_M_bubble}, {63'd0, e_mb});
         chk("W_stall",  {63'd0, a_W_stall},  {63'd0, e_ws});
         chk("set_cc",   {63'd0, a_set_cc},   {63'd0, e_cc});
         chk("halted",   {63'd0, a_halted},   {63'd0, m_halted});
         chk("prog_stat", {60'd0, a_prog_stat}, 64'(m_pstat));
         chk("cyc_cnt",   {32'd0, a_cyc},   64'(m_cnt[0][0]));
         chk("ret_cnt",   {32'd0, a_ret},   64'(m_cnt[0][1]));
         chk("stall_cnt", {32'd0, a_stall}, 64'(m_cnt[0][2]));
         chk("bub_cnt",   {32'd0, a_bub},   64'(m_cnt[0][3]));
         chk("sat_F_stall", {63'd0, b_F_stall}, {63'd0, e_fs});
         chk("sat_D_bubble", {63'd0, b_D_bubble}, {63'd0, e_db});
         chk("sat_halted", {63'd0, b_halted}, {63'd0, m_halted});
         chk("sat_cyc_cnt",   {60'd0, b_cyc},   64'(m_cnt[1][0]));
         chk("sat_ret_cnt",   {60'd0, b_ret},   64'(m_cnt[1][1]));
         chk("sat_stall_cnt", {60'd0, b_stall}, 64'(m_cnt[1][2]));
         chk("sat_bub_cnt",   {60'd0, b_bub},   64'(m_cnt[1][3]));
         // Advance the model to the state the coming rising edge will produce.
         inc[0] = 1'b1;
         inc[1] = (W_icode != 4'h1) && !wx;
         inc[2] = lu;
         inc[3] = mp;
         if (rst) begin
            m_halted = 1'b0;
            m_pstat  = 1;
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 4; j++)
                  m_cnt[i][j] = 0;
         end else if (!m_halted) begin
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 4; j++)
                  if (inc[j] && m_cnt[i][j] < m_max[i])
                     m_cnt[i][j] = m_cnt[i][j] + 1;
            if (wx) begin
               m_halted = 1'b1;
               m_pstat  = int'(W_stat);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
      E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
      M_icode = 4'h1; m_stat = 4'h1; W_icode = 4'h1; W_stat = 4'h1;
   endtask

   function automatic logic [3:0] pick_icode();
      logic [3:0] tbl [8];
      tbl = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2};
      if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
      return tbl[$urandom_range(0, 7)];
   endfunction

   function automatic logic [3:0] pick_reg();
      int r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 4'hF : 4'(r);
   endfunction

   logic [31:0] frozen;

   initial begin
      idle();
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      #3;
      chk("rst cyc_cnt",  {32'd0, a_cyc}, 64'd0);
      chk("rst prog_stat", {60'd0, a_prog_stat}, 64'd1);
      chk("rst D_bubble", {63'd0, a_D_bubble}, 64'd1);
      chk("rst E_bubble", {63'd0, a_E_bubble}, 64'd1);
      chk("rst M_bubble", {63'd0, a_M_bubble}, 64'd1);
      chk("rst F_stall",  {63'd0, a_F_stall}, 64'd0);
      chk("rst set_cc",   {63'd0, a_set_cc}, 64'd0);
      rst = 1'b0;

      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
      #3;
      chk("lu F_stall",  {63'd0, a_F_stall}, 64'd1);
      chk("lu D_stall",  {63'd0, a_D_stall}, 64'd1);
      chk("lu E_bubble", {63'd0, a_E_bubble}, 64'd1);
      chk("lu D_bubble", {63'd0, a_D_bubble}, 64'd0);
      tick();
      chk("lu stall_cnt", {32'd0, a_stall}, 64'd1);
      chk("lu cyc_cnt",   {32'd0, a_cyc}, 64'd1);

      idle(); E_icode = 4'h7; e_Cnd = 1'b0;
      #3;
      chk("mp D_bubble", {63'd0, a_D_bubble}, 64'd1);
      chk("mp E_bubble", {63'd0, a_E_bubble}, 64'd1);
      chk("mp F_stall",  {63'd0, a_F_stall}, 64'd0);
      tick();
      chk("mp bub_cnt", {32'd0, a_bub}, 64'd1);
      e_Cnd = 1'b1;
      #3;
      chk("taken all_zero", {57'd0, a_F_stall, a_D_stall, a_D_bubble, a_E_bubble,
                             a_M_bubble, a_W_stall, a_set_cc}, 64'd0);
      tick();

      idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9;
      #3;
      chk("rt+lu D_stall",  {63'd0, a_D_stall}, 64'd1);
      chk("rt+lu D_bubble", {63'd0, a_D_bubble}, 64'd0);
      tick();
      E_icode = 4'h1;
      #3;
      chk("rt F_stall",  {63'd0, a_F_stall}, 64'd1);
      chk("rt D_bubble", {63'd0, a_D_bubble}, 64'd1);
      chk("rt D_stall",  {63'd0, a_D_stall}, 64'd0);
      tick();

      idle(); W_icode = 4'h6;
      tick();
      chk("ret_cnt one", {32'd0, a_ret}, 64'd1);
      idle(); W_stat = 4'h2;
      #3;
      chk("exc W_stall", {63'd0, a_W_stall}, 64'd1);
      chk("exc halted",  {63'd0, a_halted}, 64'd0);
      tick();
      idle();
      chk("halt halted",    {63'd0, a_halted}, 64'd1);
      chk("halt prog_stat", {60'd0, a_prog_stat}, 64'd2);
      chk("halt cyc_cnt",   {32'd0, a_cyc}, 64'd7);
      chk("halt D_bubble",  {63'd0, a_D_bubble}, 64'd0);
      chk("halt F_stall",   {63'd0, a_F_stall}, 64'd1);
      frozen = a_cyc;
      tick(); tick(); tick();
      chk("halt cyc frozen", {32'd0, a_cyc}, {32'd0, frozen});
      chk("halt still", {63'd0, a_halted}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rerun halted", {63'd0, a_halted}, 64'd0);
      chk("rerun cyc_cnt", {32'd0, a_cyc}, 64'd0);
      chk("rerun prog_stat", {60'd0, a_prog_stat}, 64'd1);

      for (int i = 0; i < 20; i++) tick();
      chk("sat cyc_cnt", {60'd0, b_cyc}, 64'd15);
      chk("wide cyc_cnt", {32'd0, a_cyc}, 64'd20);
      E_icode = 4'h6; m_stat = 4'h3;
      #3;
      chk("opq mexc set_cc", {63'd0, a_set_cc}, 64'd0);
      m_stat = 4'h1;
      #1;
      chk("opq set_cc", {63'd0, a_set_cc}, 64'd1);
      tick();

      for (int i = 0; i < 4000; i++) begin
         rst     = ($urandom_range(0, 79) == 0);
         D_icode = pick_icode();
         E_icode = pick_icode();
         M_icode = pick_icode();
         W_icode = pick_icode();
         d_srcA  = pick_reg();
         d_srcB  = pick_reg();
         E_dstM  = pick_reg();
         e_Cnd   = 1'($urandom_range(0, 1));
         m_stat  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 4)) : 4'h1;
         W_stat  = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
         tick();
      end
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
